irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Parametrised, multi-channel interrupt controller that replaces the single raw `hwint` input to the CPU with `NUM_IRQ` maskable, prioritised, nestable interrupt sources. It sits beside the register file on the CPU's internal buses:

- Its control registers are read onto a tri-state bus and loaded from `result_bus`.
- It drives the CPU's `hwint` request, a vector number and a vector-valid flag.
- It accepts acknowledge and end-of-interrupt strobes from the control unit.

## Interface

**Parameters**

- `NUM_IRQ`, default 8: number of interrupt channels; legal range 1..`DATA_WIDTH`. Channel 0 has the highest priority.
- `DATA_WIDTH`, default 32: bus width; register reads are zero-extended to this width.
- `VEC_W`, default `$clog2(NUM_IRQ)` (minimum 1): width of the vector output.

**Ports**

- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `irq` input `NUM_IRQ`: raw interrupt lines, already synchronous to `clk`.
- `addr` input 2: register select (0 MASK, 1 MODE, 2 PENDING, 3 INSERVICE).
- `ld` input 1: write `in` to the selected register this cycle.
- `oe` input 1: drive the selected register onto `out`.
- `in` input `DATA_WIDTH`: write data, taken from `result_bus`.
- `out` output (tri) `DATA_WIDTH`: read data; high-Z when `oe` = 0.
- `hwint` output 1: registered interrupt request to the control unit.
- `int_ack` input 1: single-cycle acknowledge from the control unit.
- `eoi` input 1: single-cycle end-of-interrupt strobe.
- `vector` output `VEC_W`: index of the acknowledged channel.
- `vector_valid` output 1: registered; 1 if the last `int_ack` claimed a channel.

## Operation

**Registers** (`NUM_IRQ` bits each; upper bits of `in` are ignored)

- MASK (rw): 1 = channel masked.
- MODE (rw): 1 = edge-triggered, 0 = level.
- PENDING: read returns pending state; a write is write-1-to-clear and affects edge channels only.
- INSERVICE: read-only; writes are ignored.

**Pending logic**

- An edge channel's pending bit is set when `irq[i]` is 1 and its registered previous sample `irq_q[i]` is 0. It stays set until acknowledged or W1C-cleared.
- A level channel's pending bit equals `irq[i]` sampled each cycle; W1C and acknowledge have no lasting effect on it.
- If a set and a clear (W1C or ack) hit the same edge bit in the same cycle, the set wins.

**Eligibility**

- Eligible set = `pending & ~mask`.
- `best` = lowest-index eligible channel.
- `cur` = lowest-index INSERVICE bit, or none if INSERVICE is empty.
- A request exists when `best` exists and either INSERVICE is empty or `best` < `cur` (strict nesting: equal or lower priority never preempts).
- `hwint` is the registered value of this request.

**`int_ack`**

- Evaluated against state at the start of the cycle.
- If a request exists:
  - `vector` ← `best` and `vector_valid` ← 1.
  - INSERVICE[`best`] is set.
  - PENDING[`best`] is cleared if that channel is in edge mode.
- If no request exists (spurious acknowledge): `vector_valid` ← 0, `vector` holds its value, and no other state changes.

**`eoi`**

- Clears INSERVICE[`cur`].
- With INSERVICE empty it is a no-op.

**`eoi` and `int_ack` in the same cycle**

- Both are computed from pre-edge state.
- The ack's new bit is always higher priority than `cur`, so the two updates never collide.

**Register writes vs. the interrupt path**

- `ld` to MASK or MODE takes effect on the next edge.
- A request already latched in `hwint` may be withdrawn one cycle after a mask write.
- Reconfiguring MODE does not clear pending bits.

**Reset** (on a rising edge with `rst` = 0, all of the following take effect)

- MASK = all 1s, MODE = 0, PENDING = 0, INSERVICE = 0, `irq_q` = 0.
- `hwint` = 0, `vector` = 0, `vector_valid` = 0.
- `out` is high-Z whenever `oe` = 0, including during reset.
- Reset overrides `ld`, `int_ack` and `eoi` in the same cycle.

## Timing

- Edge on `irq` at edge N → pending set at edge N → `hwint` = 1 after edge N+1, i.e. two edges of latency.
- `int_ack` at edge M → `vector` and `vector_valid` valid after edge M. `hwint` re-evaluates from the new INSERVICE/PENDING state and updates after edge M+1.
- `eoi` at edge K → a lower-priority pending channel raises `hwint` after edge K+1.
- Reads are combinational from current register state: `out` is valid in the same cycle as `oe`/`addr`.
- Driven with `oe` on the negative-clock control unit, same as the register file.

## Test plan

- **Reset defaults:** hold `rst` = 0 for 2 cycles with `irq` = 0xFF → MASK reads 0xFF, PENDING reads 0xFF (level mode), `hwint` = 0, `vector_valid` = 0; after release, `hwint` stays 0 because all channels are masked.
- **Edge capture and W1C:** MODE = 0x08, MASK = 0; pulse `irq[3]` for 1 cycle → PENDING = 0x08 after the edge and `hwint` = 1 the following cycle; write PENDING = 0x08 → PENDING = 0 and `hwint` drops one cycle later.
- **Priority and ack:** level `irq[5]` and `irq[2]` both high, MASK = 0; `int_ack` → `vector` = 2, `vector_valid` = 1, INSERVICE = 0x04; `hwint` = 0 while 5 is blocked; `eoi` → INSERVICE = 0, `hwint` = 1; next `int_ack` → `vector` = 5.
- **Nesting:** channel 4 in service; raise `irq[1]` → `hwint` = 1; ack → INSERVICE = 0x12; first `eoi` clears bit 1, second `eoi` clears bit 4.
- **Spurious ack and set-wins:** ack with no eligible channel → `vector_valid` = 0 and `vector` unchanged. Edge on `irq[0]` in the same cycle as a W1C of bit 0 → PENDING bit 0 = 1.
- **Parameter sweep:** `NUM_IRQ` = 1 and `NUM_IRQ` = 32 (`VEC_W` = 5) → channel 31 ack returns `vector` = 31; reads are zero-extended above `NUM_IRQ`.

Source files
------------

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : NUM_IRQ-channel maskable, prioritised, nestable interrupt
//             controller. Channel 0 is the highest priority. Control
//             registers are read onto a tri-state bus.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int NUM_IRQ    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int VEC_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic [1:0]            addr,
    input  logic                  ld,
    input  logic                  oe,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  hwint,
    input  logic                  int_ack,
    input  logic                  eoi,
    output logic [VEC_W-1:0]      vector,
    output logic                  vector_valid
);

    localparam logic [1:0] c_ADDR_MASK  = 2'd0;
    localparam logic [1:0] c_ADDR_MODE  = 2'd1;
    localparam logic [1:0] c_ADDR_PEND  = 2'd2;
    localparam logic [1:0] c_ADDR_INSVC = 2'd3;

    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_pend;   // edge-capture storage; mirrors irq on level channels
    logic [NUM_IRQ-1:0] r_insvc;
    logic [NUM_IRQ-1:0] r_irq_q;

    logic [NUM_IRQ-1:0] w_pend_eff;
    logic [NUM_IRQ-1:0] w_elig;
    logic [VEC_W-1:0]   w_best;
    logic               w_best_vld;
    logic [VEC_W-1:0]   w_cur;
    logic               w_cur_vld;
    logic               w_req;
    logic               w_ack_take;
    logic [NUM_IRQ-1:0] w_best_oh;
    logic [NUM_IRQ-1:0] w_cur_oh;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_pend_clr;
    logic [NUM_IRQ-1:0] w_pend_set;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic [NUM_IRQ-1:0] w_insvc_nxt;
    logic [NUM_IRQ-1:0] w_rd_sel;

    // Level channels expose the live line so PENDING tracks irq every cycle
    // (including while reset is held); edge channels expose the captured bit.
    assign w_pend_eff = (r_mode & r_pend) | (~r_mode & irq);
    assign w_elig     = w_pend_eff & ~r_mask;

    // Lowest-index eligible channel and lowest-index in-service channel
    always_comb begin
        w_best     = '0;
        w_best_vld = 1'b0;
        w_cur      = '0;
        w_cur_vld  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_best     = VEC_W'(i);
                w_best_vld = 1'b1;
            end
            if (r_insvc[i]) begin
                w_cur     = VEC_W'(i);
                w_cur_vld = 1'b1;
            end
        end
    end

    // Strict nesting: only a strictly higher-priority channel preempts
    assign w_req      = w_best_vld && (!w_cur_vld || (w_best < w_cur));
    assign w_ack_take = int_ack && w_req;
    assign w_best_oh  = NUM_IRQ'(1) << w_best;
    assign w_cur_oh   = NUM_IRQ'(1) << w_cur;

    // Pending update: a new edge wins over a same-cycle W1C or acknowledge
    assign w_w1c       = (ld && (addr == c_ADDR_PEND)) ? in[NUM_IRQ-1:0] : '0;
    assign w_pend_clr  = w_w1c | (w_ack_take ? w_best_oh : '0);
    assign w_pend_set  = irq & ~r_irq_q;
    assign w_pend_nxt  = (r_mode & (w_pend_set | (r_pend & ~w_pend_clr))) | (~r_mode & irq);

    // The acked bit is always above cur, so retire and claim never collide
    assign w_insvc_nxt = (r_insvc & ~((eoi && w_cur_vld) ? w_cur_oh : '0))
                       | (w_ack_take ? w_best_oh : '0);

    // Register read mux, zero-extended onto the bus
    always_comb begin
        w_rd_sel = '0;
        case (addr)
            c_ADDR_MASK:  w_rd_sel = r_mask;
            c_ADDR_MODE:  w_rd_sel = r_mode;
            c_ADDR_PEND:  w_rd_sel = w_pend_eff;
            c_ADDR_INSVC: w_rd_sel = r_insvc;
            default:      w_rd_sel = '0;
        endcase
    end

    assign out = oe ? DATA_WIDTH'(w_rd_sel) : {DATA_WIDTH{1'bz}};

    // Register file, interrupt state and registered CPU-facing outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mask       <= '1;
            r_mode       <= '0;
            r_pend       <= '0;
            r_insvc      <= '0;
            r_irq_q      <= '0;
            hwint        <= 1'b0;
            vector       <= '0;
            vector_valid <= 1'b0;
        end else begin
            r_irq_q <= irq;
            r_pend  <= w_pend_nxt;
            r_insvc <= w_insvc_nxt;
            hwint   <= w_req;
            if (ld && (addr == c_ADDR_MASK)) begin
                r_mask <= in[NUM_IRQ-1:0];
            end
            if (ld && (addr == c_ADDR_MODE)) begin
                r_mode <= in[NUM_IRQ-1:0];
            end
            if (int_ack) begin
                vector_valid <= w_req;
                if (w_req) begin
                    vector <= w_best;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Self-checking bench for irq_ctrl: directed vector table,
//             hand-written corner sequences, randomized traffic against a
//             behavioural model, and 1- / 32-channel instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 8-channel instance
    logic        rst, ld, oe, ack, eoi;
    logic [7:0]  irq;
    logic [1:0]  addr;
    logic [31:0] din;
    wire  [31:0] dout;
    wire         hw, vv;
    wire  [2:0]  vec;

    irq_ctrl #(.NUM_IRQ(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .irq(irq), .addr(addr), .ld(ld), .oe(oe),
        .in(din), .out(dout), .hwint(hw), .int_ack(ack), .eoi(eoi),
        .vector(vec), .vector_valid(vv)
    );

    // 32-channel instance
    logic        p_rst, p_ld, p_oe, p_ack, p_eoi;
    logic [31:0] p_irq, p_din;
    logic [1:0]  p_addr;
    wire  [31:0] p_dout;
    wire         p_hw, p_vv;
    wire  [4:0]  p_vec;

    irq_ctrl #(.NUM_IRQ(32), .DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(p_rst), .irq(p_irq), .addr(p_addr), .ld(p_ld), .oe(p_oe),
        .in(p_din), .out(p_dout), .hwint(p_hw), .int_ack(p_ack), .eoi(p_eoi),
        .vector(p_vec), .vector_valid(p_vv)
    );

    // 1-channel instance on an 8-bit bus
    logic        q_rst, q_ld, q_oe, q_ack, q_eoi;
    logic [0:0]  q_irq;
    logic [7:0]  q_din;
    logic [1:0]  q_addr;
    wire  [7:0]  q_dout;
    wire         q_hw, q_vv;
    wire  [0:0]  q_vec;

    irq_ctrl #(.NUM_IRQ(1), .DATA_WIDTH(8)) dut1 (
        .clk(clk), .rst(q_rst), .irq(q_irq), .addr(q_addr), .ld(q_ld), .oe(q_oe),
        .in(q_din), .out(q_dout), .hwint(q_hw), .int_ack(q_ack), .eoi(q_eoi),
        .vector(q_vec), .vector_valid(q_vv)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        oe   = 1'b1;
        #1;
        chk(name, dout, exp);
        oe   = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_mask, m_mode, m_pe, m_irqq;
    int         m_stack[$];   // in-service channels, most recent (highest priority) at back
    bit         m_hw, m_vv;
    int         m_vec;

    task automatic model_reset();
        m_mask = 8'hFF; m_mode = 8'h00; m_pe = 8'h00; m_irqq = 8'h00;
        m_stack.delete();
        m_hw = 0; m_vv = 0; m_vec = 0;
    endtask

    function automatic logic [7:0] model_pend();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_mode[i] ? m_pe[i] : irq[i];
        return p;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = 0;
        case (a)
            2'd0: r = {24'h0, m_mask};
            2'd1: r = {24'h0, m_mode};
            2'd2: r = {24'h0, model_pend()};
            default: foreach (m_stack[k]) r[m_stack[k]] = 1'b1;
        endcase
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [7:0] eff, nxt;
        int  best, cur;
        bit  req, clr, setb;
        eff  = model_pend() & ~m_mask;
        best = -1;
        for (int i = 0; i < 8; i++) if (eff[i]) begin best = i; break; end
        cur  = -1;
        if (m_stack.size() > 0) cur = m_stack[$];
        req  = (best >= 0) && (cur < 0 || best < cur);
        m_hw = req;
        if (ack) begin
            m_vv = req;
            if (req) m_vec = best;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) begin
                clr    = (ld && addr == 2'd2 && din[i]) || (ack && req && best == i);
                setb   = irq[i] && !m_irqq[i];
                nxt[i] = setb || (m_pe[i] && !clr);
            end else begin
                nxt[i] = irq[i];
            end
        end
        m_pe = nxt;
        if (eoi && m_stack.size() > 0) void'(m_stack.pop_back());
        if (ack && req) m_stack.push_back(best);
        if (ld && addr == 2'd0) m_mask = din[7:0];
        if (ld && addr == 2'd1) m_mode = din[7:0];
        m_irqq = irq;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] irq;
        logic       ld;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       ack;
        logic       eoi;
        logic       hw;
        logic       vv;
        logic [2:0] vec;
        logic [1:0] raddr;
        logic [7:0] rval;
    } vec_t;

    vec_t tbl[15];

    initial begin
        rst = 0; ld = 0; oe = 0; ack = 0; eoi = 0; irq = 8'hFF; addr = 0; din = 0;
        p_rst = 0; p_ld = 0; p_oe = 0; p_ack = 0; p_eoi = 0; p_irq = 0; p_din = 0; p_addr = 0;
        q_rst = 0; q_ld = 0; q_oe = 0; q_ack = 0; q_eoi = 0; q_irq = 0; q_din = 0; q_addr = 0;

        //            irq    ld   addr  wdata  ack  eoi  hw   vv   vec   raddr rval
        tbl[0]  = '{8'h00, 1'b1, 2'd1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 8'h08};
        tbl[1]  = '{8'h00, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00};
        tbl[2]  = '{8'h08, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 8'h08};
        tbl[3]  = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 8'h08};
        tbl[4]  = '{8'h00, 1'b1, 2'd2, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 8'h00};
        tbl[5]  = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 8'h00};
        tbl[6]  = '{8'h24, 1'b1, 2'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 8'h00};
        tbl[7]  = '{8'h24, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 2'd3, 8'h04};
        tbl[8]  = '{8'h24, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 2'd3, 8'h04};
        tbl[9]  = '{8'h24, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 2'd3, 8'h00};
        tbl[10] = '{8'h20, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 2'd3, 8'h00};
        tbl[11] = '{8'h20, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 2'd3, 8'h20};
        tbl[12] = '{8'h20, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 2'd3, 8'h00};
        tbl[13] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd2, 8'h00};
        tbl[14] = '{8'h00, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd3, 8'h00};

        // Reset defaults: level channels follow irq even while reset is held
        for (int c = 0; c < 2; c++) begin
            tick();
            rd("rst_mask", 2'd0, 32'hFF);
            rd("rst_pend", 2'd2, 32'hFF);
            chk("rst_hwint", {31'h0, hw}, 32'h0);
            chk("rst_vv", {31'h0, vv}, 32'h0);
        end
        rst = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("masked_hwint", {31'h0, hw}, 32'h0);
        end

        // Directed table
        for (int r = 0; r < 15; r++) begin
            irq = tbl[r].irq; ld = tbl[r].ld; addr = tbl[r].addr;
            din = {24'h0, tbl[r].wdata}; ack = tbl[r].ack; eoi = tbl[r].eoi;
            tick();
            ld = 0; ack = 0; eoi = 0;
            chk($sformatf("tbl%0d_hwint", r), {31'h0, hw}, {31'h0, tbl[r].hw});
            chk($sformatf("tbl%0d_vv", r), {31'h0, vv}, {31'h0, tbl[r].vv});
            chk($sformatf("tbl%0d_vec", r), {29'h0, vec}, {29'h0, tbl[r].vec});
            rd($sformatf("tbl%0d_read", r), tbl[r].raddr, {24'h0, tbl[r].rval});
        end

        // Nesting: channel 4 in service, channel 1 preempts
        irq = 8'h10; tick();
        chk("nest_hw4", {31'h0, hw}, 32'h1);
        ack = 1; tick(); ack = 0;
        chk("nest_vec4", {29'h0, vec}, 32'd4);
        rd("nest_isr10", 2'd3, 32'h10);
        irq = 8'h12; tick();
        chk("nest_hw1", {31'h0, hw}, 32'h1);
        ack = 1; tick(); ack = 0;
        chk("nest_vec1", {29'h0, vec}, 32'd1);
        rd("nest_isr12", 2'd3, 32'h12);
        eoi = 1; tick(); eoi = 0;
        rd("nest_eoi1", 2'd3, 32'h10);
        eoi = 1; tick(); eoi = 0;
        rd("nest_eoi2", 2'd3, 32'h00);

        // Spurious acknowledge keeps the previous vector
        irq = 8'h00; tick();
        ack = 1; tick(); ack = 0;
        chk("spur_vv", {31'h0, vv}, 32'h0);
        chk("spur_vec", {29'h0, vec}, 32'd1);

        // Edge set wins over a same-cycle W1C
        ld = 1; addr = 2'd1; din = 32'h01; tick(); ld = 0;
        irq = 8'h01; ld = 1; addr = 2'd2; din = 32'h01; tick(); ld = 0;
        rd("setwins_pend", 2'd2, 32'h01);

        // Randomized traffic against the model
        irq = 0; rst = 0; tick(); rst = 1;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) irq = 8'($urandom);
            ld   = ($urandom_range(0, 7) == 0);
            addr = 2'($urandom);
            din  = (addr == 2'd0) ? ($urandom & $urandom) : $urandom;
            ack  = ($urandom_range(0, 3) == 0);
            eoi  = ($urandom_range(0, 4) == 0);
            model_step();
            tick();
            ld = 0; ack = 0; eoi = 0;
            chk("rnd_hwint", {31'h0, hw}, {31'h0, m_hw});
            chk("rnd_vv", {31'h0, vv}, {31'h0, m_vv});
            chk("rnd_vec", {29'h0, vec}, 32'(m_vec));
            begin
                logic [1:0] ra;
                ra = 2'($urandom);
                rd($sformatf("rnd_read%0d", ra), ra, model_read(ra));
            end
        end

        // 32-channel instance: lowest-priority channel acknowledged
        p_rst = 1; p_ld = 1; p_addr = 2'd0; p_din = 0; p_irq = 32'h8000_0000;
        tick(); p_ld = 0;
        tick();
        chk("p32_hwint", {31'h0, p_hw}, 32'h1);
        p_ack = 1; tick(); p_ack = 0;
        chk("p32_vec", {27'h0, p_vec}, 32'd31);
        chk("p32_vv", {31'h0, p_vv}, 32'h1);
        p_addr = 2'd3; p_oe = 1; #1;
        chk("p32_isr", p_dout, 32'h8000_0000);
        p_oe = 0;

        // 1-channel instance: reads zero-extended
        q_rst = 1; q_addr = 2'd0; q_oe = 1; #1;
        chk("p1_mask_rst", {24'h0, q_dout}, 32'h01);
        q_oe = 0;
        q_ld = 1; q_din = 8'hFE; tick(); q_ld = 0;
        q_oe = 1; #1;
        chk("p1_mask_w", {24'h0, q_dout}, 32'h00);
        q_oe = 0;
        q_irq = 1'b1; tick();
        chk("p1_hwint", {31'h0, q_hw}, 32'h1);
        q_ack = 1; tick(); q_ack = 0;
        chk("p1_vec", {31'h0, q_vec}, 32'h0);
        chk("p1_vv", {31'h0, q_vv}, 32'h1);
        q_addr = 2'd3; q_oe = 1; #1;
        chk("p1_isr", {24'h0, q_dout}, 32'h01);
        q_oe = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
